fifo_secded_sync: RTL and testbench

- Single-clock, parametrised FIFO with integrated per-byte SECDED protection: encode on write, check/correct on read.
- Also provides programmable almost-full/almost-empty flags, sticky overflow/underflow errors, and an error-injection port for safety verification.
- Next-generation replacement for the FIFO plus external safety-monitor pairing; sits in AXI4 interconnect channel buffers.

---
 rtl/fifo_secded_pkg.sv | 86 ++++++++
 rtl/fifo_secded_sync_if.sv | 42 ++++
 rtl/fifo_secded_ram.sv | 40 ++++
 rtl/fifo_secded_sync.sv | 157 +++++++++++++++
 tb/tb_fifo_secded_sync.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_secded_pkg.sv
// Shared SECDED helpers and types for the protected FIFO.
// Each byte is stored as a 13-bit word. Bits [11:0] hold Hamming(12,8)
// positions 1..12, with check bits at positions 1, 2, 4 and 8. Bit 12 is
// the overall parity over the other twelve bits.
package fifo_secded_pkg;

  localparam int CHK_PER_BYTE = 5;
  localparam int BYTE_ENC_W   = 8 + CHK_PER_BYTE;

  // Sticky error flags, MSB first: {uncorr, corr, underflow, overflow}
  typedef struct packed {
    logic uncorr;
    logic corr;
    logic underflow;
    logic overflow;
  } err_status_t;

  typedef struct packed {
    logic [7:0] data;
    logic       corr;
    logic       uncorr;
  } dec_byte_t;

  // XOR of the 1-based positions of every set bit in the 12-bit Hamming field
  function automatic logic [3:0] secded_syndrome(input logic [11:0] cw);
    logic [3:0] syn;
    syn = 4'd0;
    for (int i = 0; i < 12; i++) begin
      syn = syn ^ (cw[i] ? 4'(i + 1) : 4'd0);
    end
    return syn;
  endfunction

  function automatic logic [BYTE_ENC_W-1:0] secded_enc_byte(input logic [7:0] d);
    logic [BYTE_ENC_W-1:0] cw;
    logic [3:0]            syn;
    cw     = 13'd0;
    cw[2]  = d[0];
    cw[4]  = d[1];
    cw[5]  = d[2];
    cw[6]  = d[3];
    cw[8]  = d[4];
    cw[9]  = d[5];
    cw[10] = d[6];
    cw[11] = d[7];
    // Setting each check bit to the matching syndrome bit of the data-only
    // word brings the final syndrome to zero.
    syn    = secded_syndrome(cw[11:0]);
    cw[0]  = syn[0];
    cw[1]  = syn[1];
    cw[3]  = syn[2];
    cw[7]  = syn[3];
    cw[12] = ^cw[11:0];
    return cw;
  endfunction

  function automatic dec_byte_t secded_dec_byte(input logic [BYTE_ENC_W-1:0] code);
    logic [BYTE_ENC_W-1:0] fixed;
    logic [3:0]            syn;
    logic                  par;
    dec_byte_t             res;
    fixed      = code;
    syn        = secded_syndrome(code[11:0]);
    par        = ^code;
    res.corr   = 1'b0;
    res.uncorr = 1'b0;
    if (syn == 4'd0) begin
      // Only the overall parity bit flipped; the data is intact.
      res.corr = par;
    end else if (par) begin
      if (syn <= 4'd12) begin
        fixed[syn - 4'd1] = ~fixed[syn - 4'd1];
        res.corr = 1'b1;
      end else begin
        // A syndrome outside the codeword can only come from a multi-bit error.
        res.uncorr = 1'b1;
      end
    end else begin
      res.uncorr = 1'b1;
    end
    res.data = {fixed[11], fixed[10], fixed[9], fixed[8],
                fixed[6], fixed[5], fixed[4], fixed[2]};
    return res;
  endfunction

endpackage

// File: rtl/fifo_secded_sync_if.sv
// Interface bundle for the SECDED FIFO. The master side is the user, and the
// slave side is the FIFO.
interface fifo_secded_sync_if
  import fifo_secded_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int ENC_WIDTH = DATA_WIDTH + DATA_WIDTH / 8 * CHK_PER_BYTE;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  logic                  WriteEn;
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  ReadEn;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  DataValid;
  logic                  Empty_;
  logic                  Full_;
  logic                  HalfFull_;
  logic                  AlmostFull_;
  logic                  AlmostEmpty_;
  logic [CNT_W-1:0]      Count;
  logic                  CorrErr;
  logic                  UncorrErr;
  logic [3:0]            ErrStatus;
  logic                  ErrClear;
  logic                  InjectEn;
  logic [ENC_WIDTH-1:0]  InjectMask;

  modport master (
    output WriteEn, DataIn, ReadEn, ErrClear, InjectEn, InjectMask,
    input  DataOut, DataValid, Empty_, Full_, HalfFull_, AlmostFull_,
           AlmostEmpty_, Count, CorrErr, UncorrErr, ErrStatus
  );

  modport slave (
    input  WriteEn, DataIn, ReadEn, ErrClear, InjectEn, InjectMask,
    output DataOut, DataValid, Empty_, Full_, HalfFull_, AlmostFull_,
           AlmostEmpty_, Count, CorrErr, UncorrErr, ErrStatus
  );

endinterface

// File: rtl/fifo_secded_ram.sv
// Register-array storage for encoded FIFO words. It has one write port and
// one read port with a registered output.
// The read register is cleared by reset so that the decoded output starts at
// zero. The array contents are not reset.
module fifo_secded_ram #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [WIDTH-1:0]         rdData
);

  logic [WIDTH-1:0] memR [DEPTH];
  logic [WIDTH-1:0] rdDataR;

  // Store the encoded word on an accepted write
  always_ff @(posedge clk) begin
    if (wrEn) begin
      memR[wrAddr] <= wrData;
    end
  end

  // Capture the addressed word; hold it between reads so the output stays stable
  always_ff @(posedge clk) begin
    if (!rst_) begin
      rdDataR <= {WIDTH{1'b0}};
    end else if (rdEn) begin
      rdDataR <= memR[rdAddr];
    end
  end

  assign rdData = rdDataR;

endmodule

// File: rtl/fifo_secded_sync.sv
// Single-clock FIFO with per-byte SECDED protection. Data is encoded on write
// and checked/corrected on read. The block also keeps occupancy flags, sticky
// error status, and an error-injection path.
module fifo_secded_sync
  import fifo_secded_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_LVL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input logic              Clock,
  input logic              Reset_,
  fifo_secded_sync_if.slave bus
);

  localparam int ENC_WIDTH = DATA_WIDTH + DATA_WIDTH / 8 * CHK_PER_BYTE;
  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_C   = CW'(FIFO_DEPTH / 2);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]         wrPtrR;
  logic [AW-1:0]         rdPtrR;
  logic [CW-1:0]         countR;
  logic [CW-1:0]         countNextS;
  logic                  rdAccS;
  logic                  wrAccS;
  logic                  ovfS;
  logic                  udfS;
  logic                  validR;
  logic                  emptyR;
  logic                  fullR;
  logic                  halfR;
  logic                  afullR;
  logic                  aemptyR;
  err_status_t           errR;
  err_status_t           errNextS;
  logic [ENC_WIDTH-1:0]  encWordS;
  logic [ENC_WIDTH-1:0]  wrWordS;
  logic [ENC_WIDTH-1:0]  rdWordS;
  logic [DATA_WIDTH-1:0] dataDecS;
  logic [NBYTES-1:0]     corrVecS;
  logic [NBYTES-1:0]     uncorrVecS;
  logic                  corrPulseS;
  logic                  uncorrPulseS;

  // Decide which requests are accepted; a read makes room for a write in the same cycle
  always_comb begin
    rdAccS     = bus.ReadEn && (countR != {CW{1'b0}});
    wrAccS     = bus.WriteEn && ((countR < DEPTH_C) || rdAccS);
    ovfS       = bus.WriteEn && !wrAccS;
    udfS       = bus.ReadEn && !rdAccS;
    countNextS = countR + {{AW{1'b0}}, wrAccS} - {{AW{1'b0}}, rdAccS};
  end

  for (genvar b = 0; b < NBYTES; b++) begin : gEnc
    assign encWordS[b*BYTE_ENC_W +: BYTE_ENC_W] = secded_enc_byte(bus.DataIn[b*8 +: 8]);
  end

  assign wrWordS = encWordS ^ (bus.InjectEn ? bus.InjectMask : {ENC_WIDTH{1'b0}});

  fifo_secded_ram #(
    .WIDTH (ENC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) uRam (
    .clk    (Clock),
    .rst_   (Reset_),
    .wrEn   (wrAccS && Reset_),
    .wrAddr (wrPtrR),
    .wrData (wrWordS),
    .rdEn   (rdAccS),
    .rdAddr (rdPtrR),
    .rdData (rdWordS)
  );

  for (genvar b = 0; b < NBYTES; b++) begin : gDec
    dec_byte_t decS;
    assign decS                 = secded_dec_byte(rdWordS[b*BYTE_ENC_W +: BYTE_ENC_W]);
    assign dataDecS[b*8 +: 8]   = decS.data;
    assign corrVecS[b]          = decS.corr;
    assign uncorrVecS[b]        = decS.uncorr;
  end

  assign corrPulseS   = validR && (|corrVecS);
  assign uncorrPulseS = validR && (|uncorrVecS);

  // Advance pointers and occupancy; flags track next-state Count so they move together with it
  always_ff @(posedge Clock) begin
    if (!Reset_) begin
      wrPtrR  <= {AW{1'b0}};
      rdPtrR  <= {AW{1'b0}};
      countR  <= {CW{1'b0}};
      validR  <= 1'b0;
      emptyR  <= 1'b0;
      fullR   <= 1'b1;
      halfR   <= 1'b1;
      afullR  <= 1'b1;
      aemptyR <= 1'b0;
    end else begin
      if (wrAccS) begin
        wrPtrR <= wrPtrR + PTR_ONE;
      end
      if (rdAccS) begin
        rdPtrR <= rdPtrR + PTR_ONE;
      end
      countR  <= countNextS;
      validR  <= rdAccS;
      emptyR  <= (countNextS != {CW{1'b0}});
      fullR   <= (countNextS != DEPTH_C);
      halfR   <= (countNextS < HALF_C);
      afullR  <= (countNextS < AFULL_C);
      aemptyR <= (countNextS > AEMPTY_C);
    end
  end

  // Sticky error status: a clear drops old flags, but events in the same cycle still set them
  always_comb begin
    errNextS = errR;
    if (bus.ErrClear) begin
      errNextS = 4'b0000;
    end else begin
      errNextS = errR;
    end
    errNextS.overflow  = errNextS.overflow  | ovfS;
    errNextS.underflow = errNextS.underflow | udfS;
    errNextS.corr      = errNextS.corr      | corrPulseS;
    errNextS.uncorr    = errNextS.uncorr    | uncorrPulseS;
  end

  // Register the error status
  always_ff @(posedge Clock) begin
    if (!Reset_) begin
      errR <= 4'b0000;
    end else begin
      errR <= errNextS;
    end
  end

  assign bus.DataOut      = dataDecS;
  assign bus.DataValid    = validR;
  assign bus.Empty_       = emptyR;
  assign bus.Full_        = fullR;
  assign bus.HalfFull_    = halfR;
  assign bus.AlmostFull_  = afullR;
  assign bus.AlmostEmpty_ = aemptyR;
  assign bus.Count        = countR;
  assign bus.CorrErr      = corrPulseS;
  assign bus.UncorrErr    = uncorrPulseS;
  assign bus.ErrStatus    = errR;

endmodule

// File: tb/tb_fifo_secded_sync.sv
// Self-checking bench for fifo_secded_sync. It runs a table-driven
// fill/drain, directed corner-case sequences, and then randomized traffic.
// The randomized traffic is checked against a queue-based model that counts
// injected bit flips per byte.
module tb_fifo_secded_sync;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int EW    = DW + DW / 8 * 5;

  logic Clock  = 1'b0;
  logic Reset_ = 1'b0;

  always #5 Clock = ~Clock;

  fifo_secded_sync_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

  fifo_secded_sync #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .Clock  (Clock),
    .Reset_ (Reset_),
    .bus    (bus)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    int          expCount;
    logic        expValid;
    logic [31:0] expDout;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] care;
    logic        corr;
    logic        uncorr;
  } ent_t;

  vec_t tbl[32];
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] din,
                       input logic inj, input logic [EW-1:0] mask, input logic clr);
    bus.WriteEn    = wr;
    bus.ReadEn     = rd;
    bus.DataIn     = din;
    bus.InjectEn   = inj;
    bus.InjectMask = mask;
    bus.ErrClear   = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, {EW{1'b0}}, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Expected level flags follow directly from the occupancy thresholds
  task automatic checkLevel(input string tag, input int cnt);
    chk({tag, " Count"},        64'(bus.Count),        64'(cnt));
    chk({tag, " Empty_"},       64'(bus.Empty_),       64'(cnt != 0));
    chk({tag, " Full_"},        64'(bus.Full_),        64'(cnt != DEPTH));
    chk({tag, " HalfFull_"},    64'(bus.HalfFull_),    64'(!(cnt >= DEPTH / 2)));
    chk({tag, " AlmostFull_"},  64'(bus.AlmostFull_),  64'(!(cnt >= DEPTH - 2)));
    chk({tag, " AlmostEmpty_"}, 64'(bus.AlmostEmpty_), 64'(!(cnt <= 2)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] m;
    ent_t          e;
    ent_t          ex;
    logic [3:0]    errM;
    logic          lastCorr;
    logic          lastUncorr;

    idle();
    Reset_ = 1'b0;
    tick();
    tick();
    checkLevel("reset", 0);
    chk("reset DataValid", 64'(bus.DataValid), 64'(0));
    chk("reset DataOut",   64'(bus.DataOut),   64'(0));
    chk("reset ErrStatus", 64'(bus.ErrStatus), 64'(0));
    chk("reset CorrErr",   64'(bus.CorrErr),   64'(0));
    chk("reset UncorrErr", 64'(bus.UncorrErr), 64'(0));
    Reset_ = 1'b1;

    // Table: 16 writes, then 16 reads, all in order
    for (int i = 0; i < 16; i++) begin
      tbl[i]      = '{1'b1, 1'b0, 32'(i + 1), i + 1, 1'b0, 32'h0};
      tbl[16 + i] = '{1'b0, 1'b1, 32'h0, 15 - i, 1'b1, 32'(i + 1)};
    end
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].din, 1'b0, {EW{1'b0}}, 1'b0);
      tick();
      checkLevel($sformatf("vec%0d", i), tbl[i].expCount);
      chk($sformatf("vec%0d DataValid", i), 64'(bus.DataValid), 64'(tbl[i].expValid));
      chk($sformatf("vec%0d DataOut", i),   64'(bus.DataOut),   64'(tbl[i].expDout));
    end
    idle();
    tick();
    chk("idle DataValid", 64'(bus.DataValid), 64'(0));
    chk("hold DataOut",   64'(bus.DataOut),   64'(32'h10));
    chk("drain ErrStatus", 64'(bus.ErrStatus), 64'(0));

    // Single-bit injection is corrected
    m = {EW{1'b0}};
    m[3] = 1'b1;
    drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, m, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, {EW{1'b0}}, 1'b0);
    tick();
    chk("sbe DataValid", 64'(bus.DataValid), 64'(1));
    chk("sbe DataOut",   64'(bus.DataOut),   64'(32'hA5A5A5A5));
    chk("sbe CorrErr",   64'(bus.CorrErr),   64'(1));
    chk("sbe UncorrErr", 64'(bus.UncorrErr), 64'(0));
    idle();
    tick();
    chk("sbe CorrErr pulse", 64'(bus.CorrErr),   64'(0));
    chk("sbe ErrStatus",     64'(bus.ErrStatus), 64'(4'b0100));
    drive(1'b0, 1'b0, 32'h0, 1'b0, {EW{1'b0}}, 1'b1);
    tick();
    chk("sbe clear", 64'(bus.ErrStatus), 64'(0));

    // Double-bit injection is detected
    m = {EW{1'b0}};
    m[0] = 1'b1;
    m[1] = 1'b1;
    drive(1'b1, 1'b0, 32'h12345678, 1'b1, m, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, {EW{1'b0}}, 1'b0);
    tick();
    chk("dbe DataValid", 64'(bus.DataValid), 64'(1));
    chk("dbe UncorrErr", 64'(bus.UncorrErr), 64'(1));
    chk("dbe CorrErr",   64'(bus.CorrErr),   64'(0));
    idle();
    tick();
    chk("dbe UncorrErr pulse", 64'(bus.UncorrErr), 64'(0));
    chk("dbe ErrStatus",       64'(bus.ErrStatus), 64'(4'b1000));
    drive(1'b0, 1'b0, 32'h0, 1'b0, {EW{1'b0}}, 1'b1);
    tick();
    chk("dbe clear", 64'(bus.ErrStatus), 64'(0));

    // Overflow, then simultaneous write and read while full
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'(32'h100 + i), 1'b0, {EW{1'b0}}, 1'b0);
      tick();
    end
    checkLevel("full", 16);
    drive(1'b1, 1'b0, 32'h0BAD, 1'b0, {EW{1'b0}}, 1'b0);
    tick();
    checkLevel("ovf", 16);
    chk("ovf ErrStatus", 64'(bus.ErrStatus), 64'(4'b0001));
    drive(1'b1, 1'b1, 32'h200, 1'b0, {EW{1'b0}}, 1'b0);
    tick();
    checkLevel("full rw", 16);
    chk("full rw DataValid", 64'(bus.DataValid), 64'(1));
    chk("full rw DataOut",   64'(bus.DataOut),   64'(32'h100));
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'h0, 1'b0, {EW{1'b0}}, (i == 0));
      tick();
      chk($sformatf("drain%0d DataOut", i), 64'(bus.DataOut),
          64'((i < 15) ? 32'(32'h101 + i) : 32'h200));
    end
    checkLevel("drained", 0);
    chk("drained ErrStatus", 64'(bus.ErrStatus), 64'(0));

    // Write plus read at empty: no fall-through
    drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, {EW{1'b0}}, 1'b0);
    tick();
    chk("udf DataValid", 64'(bus.DataValid), 64'(0));
    chk("udf ErrStatus", 64'(bus.ErrStatus), 64'(4'b0010));
    checkLevel("udf", 1);
    drive(1'b0, 1'b1, 32'h0, 1'b0, {EW{1'b0}}, 1'b1);
    tick();
    chk("udf rd DataValid", 64'(bus.DataValid), 64'(1));
    chk("udf rd DataOut",   64'(bus.DataOut),   64'(32'hDEADBEEF));
    chk("udf cleared",      64'(bus.ErrStatus), 64'(0));

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(32'h300 + i), 1'b0, {EW{1'b0}}, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 32'h0, 1'b0, {EW{1'b0}}, 1'b0);
    Reset_ = 1'b0;
    tick();
    Reset_ = 1'b1;
    checkLevel("midrst", 0);
    chk("midrst DataValid", 64'(bus.DataValid), 64'(0));
    chk("midrst DataOut",   64'(bus.DataOut),   64'(0));
    idle();
    tick();
    chk("midrst idle DataValid", 64'(bus.DataValid), 64'(0));
    drive(1'b1, 1'b0, 32'hCAFEF00D, 1'b0, {EW{1'b0}}, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, {EW{1'b0}}, 1'b0);
    tick();
    chk("postrst DataValid", 64'(bus.DataValid), 64'(1));
    chk("postrst DataOut",   64'(bus.DataOut),   64'(32'hCAFEF00D));
    checkLevel("postrst", 0);

    // Randomized traffic against the reference model
    idle();
    Reset_ = 1'b0;
    tick();
    Reset_ = 1'b1;
    q.delete();
    errM       = 4'b0000;
    lastCorr   = 1'b0;
    lastUncorr = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int   wp;
      logic wr;
      logic rd;
      logic inj;
      logic clr;
      logic rdAcc;
      logic wrAcc;
      wp  = ((cyc / 100) % 2 == 0) ? 75 : 30;
      wr  = ($urandom_range(0, 99) < wp);
      rd  = ($urandom_range(0, 99) < (100 - wp));
      clr = ($urandom_range(0, 19) == 0);
      inj = ($urandom_range(0, 2) == 0);
      m   = {EW{1'b0}};
      e.data   = $urandom;
      e.care   = 32'hFFFFFFFF;
      e.corr   = 1'b0;
      e.uncorr = 1'b0;
      for (int b = 0; b < 4; b++) begin
        int k;
        int p1;
        int p2;
        k  = inj ? int'($urandom_range(0, 2)) : 0;
        p1 = $urandom_range(0, 12);
        p2 = (p1 + 1 + int'($urandom_range(0, 11))) % 13;
        if (k >= 1) begin
          m[b * 13 + p1] = 1'b1;
        end
        if (k == 2) begin
          m[b * 13 + p2] = 1'b1;
          e.uncorr = 1'b1;
          e.care[b * 8 +: 8] = 8'h00;
        end
        if (k == 1) begin
          e.corr = 1'b1;
        end
      end
      rdAcc = rd && (q.size() > 0);
      wrAcc = wr && ((q.size() < DEPTH) || rdAcc);
      ex    = '{32'h0, 32'h0, 1'b0, 1'b0};
      if (rdAcc) begin
        ex = q.pop_front();
      end
      if (wrAcc) begin
        q.push_back(e);
      end
      errM = (clr ? 4'b0000 : errM) |
             {lastUncorr, lastCorr, (rd && !rdAcc), (wr && !wrAcc)};
      drive(wr, rd, e.data, inj, m, clr);
      tick();
      checkLevel($sformatf("rnd%0d", cyc), q.size());
      chk($sformatf("rnd%0d DataValid", cyc), 64'(bus.DataValid), 64'(rdAcc));
      chk($sformatf("rnd%0d CorrErr", cyc),   64'(bus.CorrErr),   64'(rdAcc && ex.corr));
      chk($sformatf("rnd%0d UncorrErr", cyc), 64'(bus.UncorrErr), 64'(rdAcc && ex.uncorr));
      chk($sformatf("rnd%0d ErrStatus", cyc), 64'(bus.ErrStatus), 64'(errM));
      if (rdAcc) begin
        chk($sformatf("rnd%0d DataOut", cyc), 64'(bus.DataOut & ex.care), 64'(ex.data & ex.care));
      end
      lastCorr   = rdAcc && ex.corr;
      lastUncorr = rdAcc && ex.uncorr;
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
